// File: rtl/vrat_free_list_if.sv
// Rename/commit-side bundle for the vector physical register free list.
// master = rename/commit stages, slave = the free list itself.
interface vrat_free_list_if #(
   parameter int ID_WIDTH  = 6,
   parameter int CNT_WIDTH = 6
);
   logic                 reconfigure_i;
   logic                 alloc_req_i;
   logic                 alloc_valid_o;
   logic [ID_WIDTH-1:0]  alloc_id_o;
   logic                 release_en_i;
   logic [ID_WIDTH-1:0]  release_id_i;
   logic [CNT_WIDTH-1:0] free_count_o;
   logic                 empty_o;
   logic                 double_free_o;

   modport master (
      output reconfigure_i, alloc_req_i, release_en_i, release_id_i,
      input  alloc_valid_o, alloc_id_o, free_count_o, empty_o, double_free_o
   );

   modport slave (
      input  reconfigure_i, alloc_req_i, release_en_i, release_id_i,
      output alloc_valid_o, alloc_id_o, free_count_o, empty_o, double_free_o
   );
endinterface

// File: rtl/vrat_free_list.sv
// Physical vector register free list: circular FIFO of free IDs (first-word-fall-through)
// plus a free bitmap used to reject and flag double releases.
module vrat_free_list #(
   parameter int PHYS_REGS = 64,
   parameter int ARCH_REGS = 32,
   parameter int ID_WIDTH  = $clog2(PHYS_REGS),
   parameter int CNT_WIDTH = $clog2(PHYS_REGS - ARCH_REGS + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   vrat_free_list_if.slave    fl
);
   localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int PTR_W      = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;

   logic [ID_WIDTH-1:0]  mem_q    [FREE_DEPTH];
   logic [ID_WIDTH-1:0]  mem_d    [FREE_DEPTH];
   logic [ID_WIDTH-1:0]  init_mem [FREE_DEPTH];
   logic [PHYS_REGS-1:0] free_map_q, free_map_d, init_map;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 double_free_q, double_free_d;

   logic                 pop, rel_ok, rel_dup;
   logic [ID_WIDTH-1:0]  head_id;

   // Power-on image: IDs below ARCH_REGS are identity-mapped, the rest queue up in order.
   generate
      for (genvar gi = 0; gi < FREE_DEPTH; gi++) begin : g_init_mem
         assign init_mem[gi] = ID_WIDTH'(ARCH_REGS + gi);
      end
      for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_init_map
         assign init_map[gi] = (gi >= ARCH_REGS);
      end
   endgenerate

   assign head_id = mem_q[rd_ptr_q];
   assign pop     = fl.alloc_req_i && (count_q != '0);
   // Bitmap lookups use the pre-edge map, so releasing the ID being popped is a double free.
   assign rel_ok  = fl.release_en_i && !free_map_q[fl.release_id_i];
   assign rel_dup = fl.release_en_i &&  free_map_q[fl.release_id_i];

   always_comb begin
      mem_d         = mem_q;
      free_map_d    = free_map_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      double_free_d = double_free_q;
      if (fl.reconfigure_i) begin
         mem_d         = init_mem;
         free_map_d    = init_map;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         count_d       = CNT_WIDTH'(FREE_DEPTH);
         double_free_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d            = (rd_ptr_q == PTR_W'(FREE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            free_map_d[head_id] = 1'b0;
         end
         if (rel_ok) begin
            mem_d[wr_ptr_q]               = fl.release_id_i;
            wr_ptr_d                      = (wr_ptr_q == PTR_W'(FREE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            free_map_d[fl.release_id_i]   = 1'b1;
         end
         count_d       = count_q + CNT_WIDTH'(rel_ok) - CNT_WIDTH'(pop);
         double_free_d = double_free_q | rel_dup;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q         <= init_mem;
         free_map_q    <= init_map;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= CNT_WIDTH'(FREE_DEPTH);
         double_free_q <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         free_map_q    <= free_map_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         double_free_q <= double_free_d;
      end
   end

   assign fl.alloc_id_o    = head_id;
   assign fl.alloc_valid_o = (count_q != '0);
   assign fl.empty_o       = (count_q == '0);
   assign fl.free_count_o  = count_q;
   assign fl.double_free_o = double_free_q;
endmodule
